// File: rtl/rf_ctl_pkg.sv
// Shared widths and FSM encoding for the register-file write-port scheduler.
package rf_ctl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_HOLD   = 1'b1;
endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Bundle of writeback, long-unit, decode and register-file signals around the scheduler.
interface rf_wb_scheduler_if;
  import rf_ctl_pkg::*;

  logic      P_WE;
  reg_addr_t P_ADDR;
  reg_data_t P_DATA;
  logic      L_VALID;
  reg_addr_t L_ADDR;
  reg_data_t L_DATA;
  logic      L_READY;
  logic      ISSUE;
  reg_addr_t ISSUE_ADDR;
  reg_addr_t DEC_RS;
  reg_addr_t DEC_RT;
  reg_addr_t DEC_RD;
  logic      DEC_RD_WE;
  logic      STALL;
  logic      P_HOLD;
  logic      WE;
  reg_addr_t WR_ADDR;
  reg_data_t W_DATA;
  reg_mask_t BUSY;

  modport master (
    output P_WE, P_ADDR, P_DATA, L_VALID, L_ADDR, L_DATA,
    output ISSUE, ISSUE_ADDR, DEC_RS, DEC_RT, DEC_RD, DEC_RD_WE,
    input  L_READY, STALL, P_HOLD, WE, WR_ADDR, W_DATA, BUSY
  );

  modport slave (
    input  P_WE, P_ADDR, P_DATA, L_VALID, L_ADDR, L_DATA,
    input  ISSUE, ISSUE_ADDR, DEC_RS, DEC_RT, DEC_RD, DEC_RD_WE,
    output L_READY, STALL, P_HOLD, WE, WR_ADDR, W_DATA, BUSY
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy bits for long ops in flight plus the decode hazard check.
// RF_WB_BYPASS_EN: a register retiring this cycle no longer stalls decode.
module rf_scoreboard
  import rf_ctl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      issue,
  input  reg_addr_t issue_addr,
  input  logic      l_hs,
  input  reg_addr_t l_addr,
  input  reg_addr_t dec_rs,
  input  reg_addr_t dec_rt,
  input  reg_addr_t dec_rd,
  input  logic      dec_rd_we,
  output reg_mask_t busy,
  output logic      stall
);
  reg_mask_t busy_q, busy_d;
  reg_mask_t clr_mask, set_mask, eff_busy;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (l_hs) clr_mask[l_addr] = 1'b1;
    if (issue && (issue_addr != '0)) set_mask[issue_addr] = 1'b1;
    // Set is applied after clear so a same-cycle reissue keeps the bit.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

`ifdef RF_WB_BYPASS_EN
  assign eff_busy = busy_q & ~clr_mask;
`else
  assign eff_busy = busy_q;
`endif

  assign stall = eff_busy[dec_rs] | eff_busy[dec_rt] | (dec_rd_we & eff_busy[dec_rd]);
  assign busy  = busy_q;
endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port arbiter: pipeline writeback first, long unit protected from starvation.
// Optional RF_WB_BYPASS_EN (in rf_scoreboard) releases decode in the long op's retire cycle.
module rf_wb_scheduler
  import rf_ctl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  rf_wb_scheduler_if.slave  bus
);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we, l_ready, l_hs;
  reg_addr_t        wr_addr;
  reg_data_t        w_data;
  reg_mask_t        busy;
  logic             stall;

  always_comb begin
    state_d = ST_NORMAL;
    cnt_d   = '0;
    we      = 1'b0;
    l_ready = 1'b0;
    wr_addr = bus.P_ADDR;
    w_data  = bus.P_DATA;
    if (state_q == ST_HOLD) begin
      // Pipeline is frozen this cycle; the long unit owns the port.
      we      = bus.L_VALID;
      l_ready = bus.L_VALID;
      wr_addr = bus.L_ADDR;
      w_data  = bus.L_DATA;
    end else begin
      if (bus.P_WE) begin
        we = 1'b1;
      end else if (bus.L_VALID) begin
        we      = 1'b1;
        l_ready = 1'b1;
        wr_addr = bus.L_ADDR;
        w_data  = bus.L_DATA;
      end
      if (bus.L_VALID && bus.P_WE) begin
        if (cnt_q == LIMIT_M1) state_d = ST_HOLD;
        else                   cnt_d   = cnt_q + 1'b1;
      end
    end
    if (!RESET_N) begin
      we      = 1'b0;
      l_ready = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= ST_NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign l_hs = bus.L_VALID && l_ready;

  rf_scoreboard u_sb (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .issue      (bus.ISSUE),
    .issue_addr (bus.ISSUE_ADDR),
    .l_hs       (l_hs),
    .l_addr     (bus.L_ADDR),
    .dec_rs     (bus.DEC_RS),
    .dec_rt     (bus.DEC_RT),
    .dec_rd     (bus.DEC_RD),
    .dec_rd_we  (bus.DEC_RD_WE),
    .busy       (busy),
    .stall      (stall)
  );

  assign bus.WE      = we;
  assign bus.WR_ADDR = wr_addr;
  assign bus.W_DATA  = w_data;
  assign bus.L_READY = l_ready;
  assign bus.P_HOLD  = (state_q == ST_HOLD);
  assign bus.BUSY    = busy;
  assign bus.STALL   = stall;
endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Owns the single write port of the 32x32 register file and shares it between two writers: the in-order pipeline writeback stage and the long-latency unit (mul/div), which uses a valid/ready handshake.
- Keeps a per-register busy scoreboard for long ops in flight and stalls decode on RAW/WAW hazards against those registers.
- Includes a starvation counter so the long-latency unit cannot be locked out of the write port.
- Sits between the writeback stage, the mul/div unit and the register file.

Parameters:
- STARVE_LIMIT, 4: consecutive lost arbitration cycles before the pipeline writeback is held for one cycle (legal range 1..15).
- CNT_W, 4: width of the starvation counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET_N  in  1  synchronous, active-low reset.
- P_WE  in  1  pipeline writeback request.
- P_ADDR  in  5  pipeline destination register.
- P_DATA  in  32  pipeline write data.
- L_VALID  in  1  long-op result valid.
- L_ADDR  in  5  long-op destination register.
- L_DATA  in  32  long-op result.
- L_READY  out  1  long-op result accepted this cycle.
- ISSUE  in  1  long op dispatched this cycle.
- ISSUE_ADDR  in  5  destination of the dispatched long op.
- DEC_RS  in  5  decode source register 1.
- DEC_RT  in  5  decode source register 2.
- DEC_RD  in  5  decode destination register.
- DEC_RD_WE  in  1  decode instruction writes DEC_RD.
- STALL  out  1  hold decode; hazard on a busy register.
- P_HOLD  out  1  freeze the writeback stage this cycle.
- WE  out  1  to register file write enable.
- WR_ADDR  out  5  to register file write address.
- W_DATA  out  32  to register file write data.
- BUSY  out  32  scoreboard bits; bit 0 is always 0.

Behaviour:
- Reset (RESET_N=0 at posedge):
  - BUSY=0, starvation counter=0, state=NORMAL.
  - P_HOLD=0. WE=0 while in reset.
  - Reset mid-operation discards all in-flight tracking. The long unit is reset by the same RESET_N.
- Two states:
  - NORMAL: pipeline has priority.
    - If P_WE: WE=1, WR_ADDR=P_ADDR, W_DATA=P_DATA, L_READY=0.
    - Else if L_VALID: WE=1, WR_ADDR=L_ADDR, W_DATA=L_DATA, L_READY=1.
    - Else WE=0.
  - HOLD: lasts exactly 1 cycle.
    - P_HOLD=1; the pipeline retains its write and re-presents it next cycle. P_WE is ignored.
    - L_READY=L_VALID, and the L write is granted.
    - Always returns to NORMAL.
- Write path and outputs:
  - The write path is combinational, with zero latency to the register file. The register file commits at the same posedge.
  - P_HOLD is decoded from state, so it is registered.
- Starvation counter:
  - Increments on cycles where L_VALID && P_WE in NORMAL.
  - Clears on any L handshake (L_VALID && L_READY) and when L_VALID=0.
  - When it would reach STARVE_LIMIT, next state is HOLD and the counter clears.
- Scoreboard:
  - ISSUE && ISSUE_ADDR!=0 sets BUSY[ISSUE_ADDR] at the posedge.
  - An L handshake clears BUSY[L_ADDR].
  - Same register set and cleared in the same cycle: set wins.
  - ISSUE to an already-busy register is illegal; the bench asserts it never happens.
- STALL (combinational) = BUSY[DEC_RS] | BUSY[DEC_RT] | (DEC_RD_WE & BUSY[DEC_RD]).
  - Upstream gates ISSUE with !STALL.
  - A pipeline write to a busy register cannot occur, because decode stalled on WAW.
- Register 0: writes to address 0 pass through to the register file, which ignores them. BUSY[0] is never set.
- Simultaneous P_WE and L_VALID to the same address: the pipeline write goes first and the L write on a later cycle. Program order is guaranteed because the WAW stall prevents this case from reaching the port.

Optional Feature:
- RF_WB_BYPASS_EN
- Defined: a register whose BUSY bit is being cleared by an L handshake this cycle is treated as not busy for STALL. Decode proceeds and relies on the register file's same-cycle write-through.
- Undefined: STALL uses the registered BUSY only, which adds one stall cycle per long-op consumer.

Decomposition:
- Package rf_ctl_pkg holds:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - The state encoding (NORMAL=0, HOLD=1).
- Sub-module rf_scoreboard holds the BUSY register, the set/clear logic, the STALL compare and the optional bypass.
- The top holds the arbiter, the FSM and the counter.

Test Plan:
- Reset then idle: BUSY=0, WE=0, STALL=0, P_HOLD=0.
- P_WE=1 addr 5 data 0xDEADBEEF with L_VALID=1 addr 7: WE to reg 5, L_READY=0. Next cycle P_WE=0: write reg 7, L_READY=1.
- ISSUE addr 9, then DEC_RS=9: STALL=1 until the L handshake on reg 9. With RF_WB_BYPASS_EN, STALL=0 in the handshake cycle; without it, STALL=0 one cycle later.
- P_WE held high with L_VALID=1 and STARVE_LIMIT=4: after 4 lost cycles, P_HOLD=1 for exactly 1 cycle and the L write is granted.
- ISSUE addr 0: BUSY stays 0 and DEC_RS=0 never stalls. DEC_RD_WE=1, DEC_RD=9 with reg 9 busy: STALL=1 (WAW).
- RESET_N=0 while BUSY=0x0000_0200 and the counter is at 3: BUSY=0, counter=0, state NORMAL the next cycle.
